// File: rtl/crc7_serial_pkg.sv
// -----------------------------------------------------------------------------
// crc7_serial_pkg
// Shared SD-card constants and the CRC-7 single-bit step function.
// Both the serial CRC generator and its reference model use crc7_step, so there
// is exactly one definition of the LFSR update.
//   CRC7_WIDTH        : CRC register width (7)
//   CRC7_POLY         : x^7 + x^3 + 1 without the x^7 term
//   CRC7_INIT         : value after reset / clear
//   SD_CMD_FRAME_BITS : bits covered by the CRC in an SD command frame
// -----------------------------------------------------------------------------
package crc7_serial_pkg;

  localparam int              CRC7_WIDTH        = 7;
  localparam logic [6:0]      CRC7_POLY         = 7'h09;
  localparam logic [6:0]      CRC7_INIT         = 7'h00;
  localparam int              SD_CMD_FRAME_BITS = 40;

  // Advance the CRC-7 LFSR by one message bit (MSB-first, Galois form).
  // The feedback is the incoming bit XOR the bit about to shift out.
  function automatic logic [CRC7_WIDTH-1:0] crc7_step(
    input logic [CRC7_WIDTH-1:0] crc,
    input logic                  din,
    input logic [CRC7_WIDTH-1:0] poly = CRC7_POLY
  );
    logic fb;
    fb = din ^ crc[CRC7_WIDTH-1];
    return {crc[CRC7_WIDTH-2:0], 1'b0} ^ (fb ? poly : 7'h00);
  endfunction

endpackage

// File: rtl/crc7_serial.sv
// -----------------------------------------------------------------------------
// crc7_serial
// Bit-serial CRC-7 accumulator for SD command frames. The command sequencer
// clears it, shifts the 40 frame bits in MSB first (one per enabled clock) and
// then reads crc; the transmitted trailer is {crc, 1'b1}. The block knows
// nothing about frame length: it simply folds in every enabled bit.
// Ports:
//   clk    : system clock, all updates on the rising edge
//   rst_n  : asynchronous active-low reset, forces crc to INIT
//   crc    : current CRC register (bit 6 goes out first on the SD line)
//   bit_in : serial data bit, used when enable=1
//   enable : advance the LFSR by one bit
//   clear  : synchronous return to INIT, wins over enable
// -----------------------------------------------------------------------------
module crc7_serial
  import crc7_serial_pkg::*;
#(
  parameter int               WIDTH = CRC7_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = CRC7_POLY,
  parameter logic [WIDTH-1:0] INIT  = CRC7_INIT
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] crc,
  input  logic             bit_in,
  input  logic             enable,
  input  logic             clear
);

  logic [WIDTH-1:0] crc_r;
  logic [WIDTH-1:0] crc_next_s;

  // Next-state selection: clear beats enable, otherwise hold.
  always_comb begin
    crc_next_s = crc_r;
    if (clear) begin
      crc_next_s = INIT;
    end else if (enable) begin
      crc_next_s = crc7_step(crc_r, bit_in, POLY);
    end else begin
      crc_next_s = crc_r;
    end
  end

  // CRC state register with asynchronous reset to INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_r <= INIT;
    end else begin
      crc_r <= crc_next_s;
    end
  end

  // The output is the register itself, so no input reaches crc combinationally.
  assign crc = crc_r;

endmodule

// File: tb/tb_crc7_serial.sv
// -----------------------------------------------------------------------------
// tb_crc7_serial
// Directed and random bench for crc7_serial. Known SD command CRCs are checked
// against hand-computed constants; the random frames are checked every cycle
// against a model built on crc7_step.
// -----------------------------------------------------------------------------
module tb_crc7_serial;
  import crc7_serial_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [6:0] crc;
  logic       bit_in;
  logic       enable;
  logic       clear;

  int         n_cmp;
  int         n_fail;
  logic [6:0] model;

  crc7_serial dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .crc    (crc),
    .bit_in (bit_in),
    .enable (enable),
    .clear  (clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: inputs applied on the falling edge, settle 1 time unit after
  // the rising edge. The model follows the same priority rules.
  task automatic drive(input logic c, input logic e, input logic b);
    @(negedge clk);
    clear  = c;
    enable = e;
    bit_in = b;
    @(posedge clk);
    if (!rst_n)  model = 7'h00;
    else if (c)  model = 7'h00;
    else if (e)  model = crc7_step(model, b);
    #1;
  endtask

  // Clear, then shift a frame MSB first, optionally with random idle gaps
  // whose bit_in values must be ignored.
  task automatic feed_frame(input logic [39:0] f, input bit gaps, input bit check_each);
    drive(1'b1, 1'b0, 1'b0);
    for (int i = SD_CMD_FRAME_BITS - 1; i >= 0; i--) begin
      if (gaps) begin
        int ng;
        ng = (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
        for (int g = 0; g < ng; g++) begin
          drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
          if (check_each) begin
            n_cmp++;
            if (crc !== model) begin
              n_fail++;
              $display("FAIL random_gap: crc=%h expected=%h", crc, model);
            end
          end
        end
      end
      drive(1'b0, 1'b1, f[i]);
      if (check_each) begin
        n_cmp++;
        if (crc !== model) begin
          n_fail++;
          $display("FAIL random_bit: crc=%h expected=%h", crc, model);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_frame(input string name, input logic [39:0] f, input bit gaps,
                             input logic [6:0] exp);
    feed_frame(f, gaps, 1'b0);
    n_cmp++;
    if (crc !== exp) begin
      n_fail++;
      $display("FAIL %s: crc=%h expected=%h", name, crc, exp);
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    clear  = 1'b0;
    enable = 1'b0;
    bit_in = 1'b0;
    model  = 7'h00;
    #2;
    n_cmp++;
    if (crc !== 7'h00) begin
      n_fail++;
      $display("FAIL reset_initial: crc=%h expected=00", crc);
    end
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (crc !== 7'h00) begin
      n_fail++;
      $display("FAIL reset_holds: crc=%h expected=00", crc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (crc !== 7'h00) begin
      n_fail++;
      $display("FAIL zero_length: crc=%h expected=00", crc);
    end
  endtask

  task automatic test_known_commands();
    check_frame("cmd0",   40'h40_0000_0000, 1'b0, 7'h4A);
    check_frame("cmd8",   40'h48_0000_01AA, 1'b0, 7'h43);
    check_frame("cmd8_gaps", 40'h48_0000_01AA, 1'b1, 7'h43);
    check_frame("cmd17",  40'h51_0000_0000, 1'b0, 7'h2A);
    check_frame("cmd55",  40'h77_0000_0000, 1'b0, 7'h32);
    check_frame("acmd41", 40'h69_4000_0000, 1'b0, 7'h3B);
    // Trailer byte check on the CMD0 result.
    check_frame("cmd0_again", 40'h40_0000_0000, 1'b0, 7'h4A);
    n_cmp++;
    if ({crc, 1'b1} !== 8'h95) begin
      n_fail++;
      $display("FAIL cmd0_trailer: trailer=%h expected=95", {crc, 1'b1});
    end
  endtask

  task automatic test_hold();
    // After a frame, idle cycles with toggling bit_in must not move crc.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'(i));
    n_cmp++;
    if (crc !== 7'h4A) begin
      n_fail++;
      $display("FAIL hold: crc=%h expected=4a", crc);
    end
  endtask

  task automatic test_clear_priority();
    logic [39:0] f;
    f = 40'h40_0000_0000;
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 39; i >= 20; i--) drive(1'b0, 1'b1, f[i]);
    n_cmp++;
    if (crc !== model || crc === 7'h00) begin
      n_fail++;
      $display("FAIL partial_cmd0: crc=%h expected=%h (nonzero)", crc, model);
    end
    drive(1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (crc !== 7'h00) begin
      n_fail++;
      $display("FAIL clear_priority: crc=%h expected=00", crc);
    end
    drive(1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (crc !== 7'h00) begin
      n_fail++;
      $display("FAIL clear_held: crc=%h expected=00", crc);
    end
    check_frame("cmd0_after_clear", 40'h40_0000_0000, 1'b0, 7'h4A);
  endtask

  task automatic test_async_reset();
    logic [39:0] f;
    f = 40'h48_0000_01AA;
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 39; i >= 30; i--) drive(1'b0, 1'b1, f[i]);
    n_cmp++;
    if (crc !== model || crc === 7'h00) begin
      n_fail++;
      $display("FAIL partial_cmd8: crc=%h expected=%h (nonzero)", crc, model);
    end
    // Mid-cycle reset pulse, well clear of both clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (crc !== 7'h00) begin
      n_fail++;
      $display("FAIL async_reset: crc=%h expected=00", crc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model = 7'h00;
    check_frame("cmd8_after_reset", 40'h48_0000_01AA, 1'b0, 7'h43);
  endtask

  task automatic test_random();
    for (int n = 0; n < 1000; n++) begin
      logic [39:0] f;
      f = {8'($urandom), 32'($urandom)};
      feed_frame(f, 1'b1, 1'b1);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_known_commands();
    test_hold();
    test_clear_priority();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/crc7_serial.md
Name: crc7_serial

Overview:
- Bit-serial CRC-7 generator for SD-card command frames.
- Polynomial x^7 + x^3 + 1, initial value 0, no final XOR.
- The SD command sequencer feeds the 40 frame bits (start bit, transmission bit, 6-bit index, 32-bit argument) MSB first, one per enabled clock, then reads the 7-bit CRC.
- Purely sequential accumulator; it has no knowledge of frame length.

Parameters:
- WIDTH, 7, CRC register width. Fixed at 7 for SD; other values are out of scope.
- POLY, 7'h09, generator polynomial without the x^7 term (bits 3 and 0 set).
- INIT, 7'h00, value loaded by reset and by clear.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- crc  output  7  current CRC register. Bit 6 is transmitted first on the SD line.
- bit_in  input  1  serial data bit, sampled on a rising edge when enable=1.
- enable  input  1  when 1, advance the LFSR by one bit using bit_in.
- clear  input  1  synchronous clear to INIT; has priority over enable.

Behaviour:
- Reset:
  - rst_n low immediately forces crc = INIT (0), independent of clk.
  - Deassertion takes effect at the next rising edge; no synchronizer inside the block.
- Per rising edge, when rst_n is high, in priority order:
  1. clear=1: crc <= INIT. The enable and bit_in values on that edge are ignored.
  2. clear=0, enable=1:
     - fb = bit_in ^ crc[6]
     - crc <= {crc[5:0], 1'b0} ^ (fb ? POLY : 0)
     - Equivalently: crc[0]<=fb, crc[1]<=crc[0], crc[2]<=crc[1], crc[3]<=crc[2]^fb, crc[4]<=crc[3], crc[5]<=crc[4], crc[6]<=crc[5].
  3. Otherwise: crc holds its value.
- Latency:
  - crc reflects a bit one cycle after the edge that sampled it.
  - After N enabled edges, crc equals the CRC of those N bits.
- crc is a registered output with no combinational path from the inputs.
- Holding enable low for any number of cycles between bits does not change the result. Gaps are legal.
- clear held high for multiple cycles keeps crc at INIT.
- Reset asserted mid-stream discards all accumulated state. Reset overrides clear and enable.
- Zero-length message: crc = 0.
- Frame usage by the sequencer:
  - Sequence: clear, 40 enabled bits, then read crc.
  - Transmitted trailer = {crc[6:0], 1'b1}, with crc sent MSB first.
- No X-propagation tolerance: bit_in must be valid whenever enable=1.

Decomposition:
- Shared SD package holds:
  - CRC7_WIDTH = 7, CRC7_POLY = 7'h09, CRC7_INIT = 7'h00
  - SD_CMD_FRAME_BITS = 40
  - a function crc7_step(crc, bit) returning the next value
- The RTL and the bench's reference model both use crc7_step.
- No sub-module; a single flat module.

Test Plan:
- CMD0: clear, then feed 0x40_0000_0000 (40 bits, MSB first) -> crc = 7'h4A (trailer byte 0x95).
- CMD8 arg 0x000001AA: feed 0x48_0000_01AA -> crc = 7'h43 (trailer 0x87). Repeat with random enable gaps between bits -> same 7'h43.
- CMD17 arg 0 (0x51_0000_0000) -> 7'h2A.
- CMD55 arg 0 (0x77_0000_0000) -> 7'h32.
- ACMD41 arg 0x40000000 (0x69_4000_0000) -> 7'h3B.
- Clear priority: feed 20 bits of CMD0, then assert clear and enable together with bit_in=1 -> next cycle crc = 0. Restart CMD0 -> 7'h4A.
- Async reset mid-stream: feed 10 bits, pulse rst_n low between clock edges -> crc = 0 immediately, before the next edge. Full CMD8 afterwards -> 7'h43.
- Random regression: 1000 random 40-bit frames with random enable gaps. Compare against crc7_step model every cycle.
